dmem_sram_responder: RTL

- Memory-side responder for the CPU data port; the far end of the pipeline's memory-stage request/stall interface.
- Accepts one request at a time: enable, byte write strobes, address, write data.
- Holds the pipeline with a stall request for a programmable number of wait states.
- Performs the access on an internal word-addressed array and returns read data.

---
 rtl/dmem_sram_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/dmem_sram_responder.sv
// rtl/dmem_sram_responder.sv - CPU data-port SRAM responder with programmable wait states
module dmem_sram_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        rdata_valid,
    output logic        stall_req
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter preload; the zero-wait build never enters S_WAIT, so clamp to keep it legal.
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_t              state;
    logic [3:0]          cnt;
    logic [31:0]         mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0]   idx;
    logic                commit;
    logic                is_read;
    logic                unused_addr_bits;

    // Byte offset and bits above the array are ignored, so addresses alias.
    assign idx              = mem_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
    assign is_read          = (mem_wen == 4'b0000);

    // Access commits in the last stalled cycle: IDLE when there are no wait states, else WAIT with counter at zero.
    assign commit = rst && mem_en &&
                    (((state == S_IDLE) && NO_WAIT) ||
                     ((state == S_WAIT) && (cnt == 4'd0)));

    // Stall is combinational so the pipeline holds in the very cycle the request appears.
    assign stall_req = rst && mem_en && ((state == S_IDLE) || (state == S_WAIT));

    // Storage array: only strobed byte lanes are written; never reset.
    always_ff @(posedge clk) begin
        if (commit && !is_read) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wen[b]) begin
                    mem[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Request sequencing, wait-state counting and registered read response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            mem_rdata   <= 32'h0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_en) begin
                        if (NO_WAIT) begin
                            state <= S_DONE;
                        end else begin
                            cnt   <= WAIT_INIT;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!mem_en) begin
                        // Flush dropped the request: abandon it without committing.
                        cnt   <= 4'd0;
                        state <= S_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Inputs still show the served request here, so mem_en is ignored.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
            if (commit && is_read) begin
                mem_rdata   <= mem[idx];
                rdata_valid <= 1'b1;
            end
        end
    end

endmodule
